// File: rtl/adder_arbiter.sv
// Shares one signed W-bit adder among four requesters: grant, compute, hold result until ack.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed highest-index priority.
module adder_arbiter #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   x_flat,
    input  logic [N*W-1:0]   y_flat,
    input  logic [N-1:0]     cin,
    input  logic             ack,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       owner,
    output logic [W-1:0]     sum,
    output logic             carryout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] x_q, y_q, x_next, y_next;
    logic         cin_q, cin_next;
    logic [N-1:0] gnt_next;
    logic         busy_next, done_next, carry_next, ovf_next;
    logic [1:0]   owner_next, win;
    logic [W-1:0] sum_next;
    logic [W:0]   add_full;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr, ptr_next, idx;

    // Walk downward from the farthest offset so the nearest requester at/after ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) win = idx;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) win = 2'(i);
        end
    end
`endif

    assign add_full = {1'b0, x_q} + {1'b0, y_q} + {{W{1'b0}}, cin_q};

    always_comb begin
        state_next = state;
        gnt_next   = '0;
        busy_next  = busy;
        done_next  = done;
        owner_next = owner;
        x_next     = x_q;
        y_next     = y_q;
        cin_next   = cin_q;
        sum_next   = sum;
        carry_next = carryout;
        ovf_next   = overflow;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_next   = ptr;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_next   = N'(1) << win;
                    owner_next = win;
                    x_next     = x_flat[win*W +: W];
                    y_next     = y_flat[win*W +: W];
                    cin_next   = cin[win];
                    busy_next  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                sum_next   = add_full[W-1:0];
                carry_next = add_full[W];
                ovf_next   = (x_q[W-1] == y_q[W-1]) && (add_full[W-1] != x_q[W-1]);
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (ack) begin
                    done_next  = 1'b0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_next   = owner + 2'd1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            owner    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cin_q    <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr      <= '0;
`endif
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            busy     <= busy_next;
            done     <= done_next;
            owner    <= owner_next;
            x_q      <= x_next;
            y_q      <= y_next;
            cin_q    <= cin_next;
            sum      <= sum_next;
            carryout <= carry_next;
            overflow <= ovf_next;
`ifdef ARB_ROUND_ROBIN_EN
            ptr      <= ptr_next;
`endif
        end
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one signed W-bit ripple adder (same function as the addern datapath: S, carryout, overflow) among 4 requesters.
- Picks one requester per transaction with a priority encoder, captures its operands, computes, and holds the result until the owner acknowledges.
- Sits between the requester-side logic and the adder datapath in top; the bench drives requests from the random generator.

Parameters:
- W, 8, operand/result width in bits (signed two's complement).
- N, 4, number of requesters (fixed at 4; not to be overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; level, held until that requester's ack.
- x_flat  input  4*W  operand X per requester; requester i uses bits [i*W +: W].
- y_flat  input  4*W  operand Y per requester, same packing.
- cin  input  4  carry-in per requester.
- ack  input  1  result accepted by current owner; sampled only in state DONE.
- gnt  output  4  one-hot grant; high for exactly one cycle when operands are captured.
- busy  output  1  high in CALC and DONE.
- done  output  1  result valid; held high until ack.
- owner  output  2  index of current owner; valid while busy.
- sum  output  W  registered X+Y+cin, low W bits.
- carryout  output  1  unsigned carry out of bit W-1.
- overflow  output  1  signed overflow: X, Y same sign and sum sign differs.

Behaviour:
- Reset (async, rst_n=0): state IDLE; gnt=0, busy=0, done=0, owner=0, sum=0, carryout=0, overflow=0; rotating pointer=0. Release is synchronous to next clk edge.
- FSM states IDLE, CALC, DONE; all outputs registered.
- IDLE: if any req, select winner w, register gnt=onehot(w), owner=w, latch X/Y/cin of w, go CALC. Else stay; gnt=0.
- CALC (1 cycle): gnt returns to 0; register sum/carryout/overflow from latched operands; set done=1; go DONE.
- DONE: hold done and results stable. On ack=1: clear done/busy, go IDLE. Pointer = owner+1 mod 4 (round-robin build only).
- Latency: req rising in cycle n (IDLE) -> gnt in n+1 -> done in n+2. Minimum 3 cycles between consecutive grants (ack on the first DONE cycle).
- Operands are sampled only at grant; later changes on x_flat/y_flat/cin do not affect the result.
- Requests changing while busy are ignored until IDLE. Owner dropping req while busy does not abort the transaction.
- ack outside DONE is ignored. ack held high across transactions completes each on its first DONE cycle.
- Owner must drop req in the cycle after ack, or it competes again in IDLE.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight result is lost.
- Arithmetic: full W+1-bit unsigned sum; carryout = bit W; overflow = (X[W-1]==Y[W-1]) && (sum[W-1]!=X[W-1]).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the winner is the first requesting index at or after the rotating pointer, scanning upward mod 4. Pointer updates on ack to owner+1, so every continuously requesting requester is served within 4 transactions.
- Undefined: fixed priority, highest index wins (req[3] > req[2] > req[1] > req[0]), matching priority_encoder. No pointer register.

Test Plan:
- Reset mid-operation: req=0001, X0=5, Y0=3, cin0=0; assert rst_n=0 in CALC -> all outputs 0 immediately; after release and ack, no spurious done.
- Single request: req=0001, X0=5, Y0=3, cin0=1 -> gnt=0001 one cycle later; next cycle done=1, sum=9, carryout=0, overflow=0, owner=0; done holds until ack.
- Signed overflow: X=100, Y=50, cin=0 on req[2] -> sum=-106 (0x96), overflow=1, carryout=0. Then X=-1, Y=-1 -> sum=-2, carryout=1, overflow=0.
- Contention, fixed priority: req=1111 held, ack each done -> owners 3,3,3,...
- Contention, ARB_ROUND_ROBIN_EN: req=1111 held, ack each done -> owners 0,1,2,3,0.
- Operand stability: change X0 from 5 to 7 the cycle after gnt -> sum still reflects 5. ack asserted in IDLE/CALC is ignored and done stays until an ack arrives in DONE.
